// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiply sequencer and related controllers.
package mult_pkg;

  localparam int unsigned DefAW = 64;
  localparam int unsigned DefBW = 64;

  // Sequencer states: arbitrate, low-half pass, high-half pass, result hold.
  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo NREQ. Pointer bookkeeping is left to the caller.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic found;

  // Scan offsets from the pointer outward; the first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (((32'(ptr) + i) % NREQ) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_rr_sequencer.sv
// Round-robin sequencer for a shared 32x64 carry-save partial-product unit. Runs a 64x64
// unsigned multiply as two passes (low half of A, then high half) and accumulates the
// carry-save pair into a full-width product tagged with the owning requester's index.
module mult_rr_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned A_W  = DefAW,
  parameter int unsigned B_W  = DefBW,
  parameter int unsigned ID_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  output logic [A_W/2-1:0]      pp_in0,
  output logic [B_W-1:0]        pp_in1,
  input  logic [A_W/2+B_W-1:0]  pp_a,
  input  logic [A_W/2+B_W-1:0]  pp_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [A_W+B_W-1:0]    res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);

  localparam int unsigned HW = A_W / 2;
  localparam int unsigned PW = HW + B_W;
  localparam int unsigned RW = A_W + B_W;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, win_id;
  logic [A_W-1:0]  a_q, a_sel;
  logic [B_W-1:0]  b_q, b_sel;
  logic [RW-1:0]   acc_q, acc_d;
  logic [PW:0]     pp_sum;
  logic [NREQ-1:0] gnt;
  logic            grant;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Keep the carry out of the carry-save add so nothing is lost before the shift.
  assign pp_sum = {1'b0, pp_a} + {1'b0, pp_b};
  assign grant  = (state_q == StIdle) && (|gnt);

  // Decode the one-hot grant into the winner's index and operands.
  always_comb begin
    win_id = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        win_id = ID_W'(j);
        a_sel  = req_a[j*A_W +: A_W];
        b_sel  = req_b[j*B_W +: B_W];
      end
    end
    if ((32'(win_id) + 32'd1) >= NREQ) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_id + ID_W'(1);
    end
  end

  // Next state, accumulator update and all datapath/handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    req_ready = '0;
    pp_in0    = '0;
    pp_in1    = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_id    = '0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        // Grant is combinational from req_valid; hold it off while reset is asserted.
        if (rst) begin
          req_ready = gnt;
        end
        if (|gnt) begin
          state_d = StLo;
        end
      end
      StLo: begin
        pp_in0  = a_q[HW-1:0];
        pp_in1  = b_q;
        acc_d   = RW'(pp_sum);
        state_d = StHi;
      end
      StHi: begin
        pp_in0  = a_q[A_W-1:HW];
        pp_in1  = b_q;
        acc_d   = acc_q + (RW'(pp_sum) << HW);
        state_d = StDone;
      end
      StDone: begin
        res_valid = 1'b1;
        res_data  = acc_q;
        res_id    = id_q;
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, accumulator and operand capture; operands and pointer only move on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (grant) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        id_q  <= win_id;
        ptr_q <= ptr_d;
      end
    end
  end

endmodule

// File: tb/tb_mult_rr_sequencer.sv
// Self-checking bench for mult_rr_sequencer with a behavioural carry-save partial-product unit.
module tb_mult_rr_sequencer;

  localparam int unsigned NREQ = 2;
  localparam int unsigned A_W  = 64;
  localparam int unsigned B_W  = 64;
  localparam int unsigned ID_W = 1;
  localparam int unsigned PW   = A_W / 2 + B_W;
  localparam int unsigned RW   = A_W + B_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a = '0;
  logic [NREQ*B_W-1:0] req_b = '0;
  logic [A_W/2-1:0]    pp_in0;
  logic [B_W-1:0]      pp_in1;
  logic [PW-1:0]       pp_a, pp_b;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [RW-1:0]       res_data;
  logic [ID_W-1:0]     res_id;
  logic                busy;

  // Partial-product model: exact product split randomly into sum/carry words.
  logic [PW-1:0] pp_prod;
  logic [PW-1:0] pp_mask = '1;
  assign pp_prod = PW'(pp_in0) * PW'(pp_in1);
  assign pp_a    = pp_prod & pp_mask;
  assign pp_b    = pp_prod - pp_a;

  always #5 clk = ~clk;
  always @(posedge clk) pp_mask <= {$urandom, $urandom, $urandom};

  mult_rr_sequencer #(
    .NREQ (NREQ),
    .A_W  (A_W),
    .B_W  (B_W),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .pp_in0    (pp_in0),
    .pp_in1    (pp_in1),
    .pp_a      (pp_a),
    .pp_b      (pp_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [RW-1:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   exp_ptr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for res_valid, accepts it, and returns what was presented.
  task automatic collect(input int budget, output bit seen, output int cycles,
                         output logic [RW-1:0] data, output logic [ID_W-1:0] id);
    cycles = 0;
    while (res_valid !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    seen = (res_valid === 1'b1);
    data = res_data;
    id   = res_id;
    if (seen) begin
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
    req_valid = 2'b11;
    #2;
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
    end
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", res_valid, busy);
    end
    total++;
    if (res_data !== '0 || res_id !== '0) begin
      bad++; $display("FAIL reset_result: got data=%0h id=%0h want 0 0", res_data, res_id);
    end
    total++;
    if (pp_in0 !== '0 || pp_in1 !== '0) begin
      bad++; $display("FAIL reset_pp: got in0=%0h in1=%0h want 0 0", pp_in0, pp_in1);
    end
    req_valid = '0;
    step();
    step();
    rst     = 1'b1;
    exp_ptr = 0;
  endtask

  // One request from requester 0; checks grant, both passes, latency and product.
  task automatic test_single(input logic [63:0] a, input logic [63:0] b, input string name);
    bit              seen;
    int              cyc;
    logic [RW-1:0]   d;
    logic [ID_W-1:0] id;
    exp_t            e;
    req_a[63:0] = a;
    req_b[63:0] = b;
    req_valid   = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL %s_grant: got %b want 01", name, req_ready);
    end
    exp_q.push_back('{id: '0, data: RW'(a) * RW'(b)});
    exp_ptr = 1;
    step();
    req_valid = '0;
    total++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || pp_in0 !== a[31:0] || pp_in1 !== b) begin
      bad++;
      $display("FAIL %s_lo: got rdy=%b busy=%b in0=%0h in1=%0h want 00 1 %0h %0h",
               name, req_ready, busy, pp_in0, pp_in1, a[31:0], b);
    end
    step();
    total++;
    if (pp_in0 !== a[63:32] || pp_in1 !== b) begin
      bad++; $display("FAIL %s_hi: got in0=%0h want %0h", name, pp_in0, a[63:32]);
    end
    // From HI, DONE is one edge away: res_valid three cycles after the grant cycle.
    collect(8, seen, cyc, d, id);
    total++;
    if (!seen || cyc != 1) begin
      bad++; $display("FAIL %s_latency: got seen=%0d cycles=%0d want 1 1", name, seen, cyc);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (d !== e.data || id !== e.id) begin
        bad++; $display("FAIL %s_result: got %0h/%0h want %0h/%0h", name, d, id, e.data, e.id);
      end
    end
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_release: got valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  // Both requesters continuously valid: grants must alternate starting at the pointer.
  task automatic test_alternate();
    bit              seen;
    int              cyc;
    int              w;
    logic [RW-1:0]   d;
    logic [ID_W-1:0] id;
    logic [1:0]      want;
    exp_t            e;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      w       = exp_ptr;
      want    = '0;
      want[w] = 1'b1;
      total++;
      if (req_ready !== want) begin
        bad++; $display("FAIL alt_grant%0d: got %b want %b", k, req_ready, want);
      end
      exp_q.push_back('{id: ID_W'(w), data: RW'(req_a[w*A_W +: A_W]) * RW'(req_b[w*B_W +: B_W])});
      exp_ptr = (w + 1) % NREQ;
      step();
      req_a[w*A_W +: A_W] = {$urandom, $urandom};
      req_b[w*B_W +: B_W] = {$urandom, $urandom};
      collect(8, seen, cyc, d, id);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (!seen || d !== e.data || id !== e.id) begin
          bad++;
          $display("FAIL alt_result%0d: got seen=%0d %0h/%0h want %0h/%0h",
                   k, seen, d, id, e.data, e.id);
        end
      end
    end
    req_valid = '0;
  endtask

  // Result held for 10 cycles with res_ready low while another requester waits.
  task automatic test_hold();
    int            n;
    logic [RW-1:0] d0;
    logic [0:0]    id0;
    bit            seen;
    int            cyc;
    logic [RW-1:0] d;
    logic [ID_W-1:0] id;
    exp_t          e;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL hold_grant: got %b want 10", req_ready);
    end
    exp_q.push_back('{id: 1'b1, data: RW'(req_a[127:64]) * RW'(req_b[127:64])});
    exp_ptr = 0;
    step();
    req_valid = 2'b01;
    n = 0;
    while (res_valid !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    d0  = res_data;
    id0 = res_id;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (res_valid !== 1'b1 || res_data !== d0 || res_id !== id0 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL hold_stable%0d: got v=%b d=%0h id=%0h rdy=%b want 1 %0h %0h 00",
                 i, res_valid, res_data, res_id, req_ready, d0, id0);
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (res_valid !== 1'b1 || res_data !== e.data || res_id !== e.id) begin
        bad++;
        $display("FAIL hold_result: got v=%b %0h/%0h want 1 %0h/%0h",
                 res_valid, res_data, res_id, e.data, e.id);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || req_ready !== 2'b01) begin
      bad++; $display("FAIL hold_complete: got v=%b rdy=%b want 0 01", res_valid, req_ready);
    end
    exp_q.push_back('{id: 1'b0, data: RW'(req_a[63:0]) * RW'(req_b[63:0])});
    exp_ptr = 1;
    step();
    req_valid = '0;
    collect(8, seen, cyc, d, id);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (!seen || d !== e.data || id !== e.id) begin
        bad++; $display("FAIL hold_waiter: got %0h/%0h want %0h/%0h", d, id, e.data, e.id);
      end
    end
  endtask

  // Reset during HI aborts the operation; pointer restarts at 0 and no stale result appears.
  task automatic test_reset_mid();
    bit              seen;
    int              cyc;
    logic [RW-1:0]   d;
    logic [ID_W-1:0] id;
    exp_t            e;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    step();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b00 ||
        pp_in0 !== '0 || pp_in1 !== '0 || res_data !== '0 || res_id !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got busy=%b v=%b rdy=%b in0=%0h in1=%0h d=%0h want all 0",
               busy, res_valid, req_ready, pp_in0, pp_in1, res_data);
    end
    req_valid = '0;
    step();
    step();
    rst     = 1'b1;
    exp_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (res_valid !== 1'b0) begin
        bad++; $display("FAIL midreset_stale%0d: got res_valid=%b want 0", i, res_valid);
      end
    end
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL midreset_ptr: got %b want 01", req_ready);
    end
    exp_q.push_back('{id: 1'b0, data: RW'(req_a[63:0]) * RW'(req_b[63:0])});
    exp_ptr = 1;
    step();
    req_valid = '0;
    collect(8, seen, cyc, d, id);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (!seen || d !== e.data || id !== e.id) begin
        bad++; $display("FAIL midreset_result: got %0h/%0h want %0h/%0h", d, id, e.data, e.id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(64'd3, 64'd5, "small");
    test_single(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "max");
    test_single(64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, "hionly");
    test_alternate();
    test_hold();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
